ral_reg_bank: RTL
=================

# ral_reg_bank

Parametrised register bank for the RAL test application, with a request/ready handshake and deferred, latency-controlled writes. Address 0 is a read-only pseudo-random status register, built from a synthesisable Galois LFSR. Addresses 1..2**AW-1 are byte-maskable read/write storage. The block sits behind the UVM RAL adapter as the DUT register model target and replaces the fixed 8-bit/7-entry bank.

## Interface
- DW, default 8: data width; must be a multiple of 8.
- AW, default 3: address width; the bank has 2**AW locations, with location 0 reserved.
- WR_LAT, default 4: cycles from write acceptance to commit; legal range is 1..15.
- LFSR_POLY, default 8'hB8: Galois feedback taps, DW bits wide.
- LFSR_SEED, default 8'h01: LFSR reset value, DW bits wide; must be nonzero.
- clk  in  1: clock.
- rst_n  in  1: reset, asynchronous, active-low.
- req_i  in  1: request valid.
- we_i  in  1: 1 = write, 0 = read.
- addr_i  in  AW: register address.
- wdata_i  in  DW: write data.
- wstrb_i  in  DW/8: byte enables for writes.
- ready_o  out  1: block can accept a request.
- rvalid_o  out  1: rdata_o is valid; single-cycle pulse.
- rdata_o  out  DW: read data; holds its last value when rvalid_o is low.
- err_o  out  1: single-cycle pulse for an illegal access.
- busy_o  out  1: a write is pending (equals ~ready_o).

## Operation
- A request is accepted on a rising edge where req_i && ready_o.
- Read of address 0:
  - rdata_o is loaded with the current LFSR value.
  - The LFSR then advances one step, on the same edge.
  - The LFSR advances only on accepted reads of address 0.
- Read of addresses 1..N-1: rdata_o is loaded with bank[addr_i].
- Any accepted read: rvalid_o = 1 in the following cycle.
- Write to addresses 1..N-1:
  - addr_i, wdata_i and wstrb_i are captured.
  - The FSM moves IDLE -> PEND, and ready_o drops.
- Write to address 0:
  - No state change and no busy period.
  - err_o = 1 in the following cycle.
- FSM states:
  - IDLE: ready_o = 1.
  - PEND: the down-counter cnt is loaded with WR_LAT-1 at acceptance. Each cycle cnt decrements.
  - PEND exit: on the edge where cnt == 0, the captured bytes with strobe = 1 are written into bank and the FSM returns to IDLE.
- Write with wstrb_i = 0:
  - Still accepted, and still takes the full WR_LAT busy period.
  - Commits nothing.
- Requests during PEND are ignored: no err_o, no rvalid_o. The requester must hold req_i until it sees ready_o.

## Timing
- Reset values:
  - ready_o = 1, busy_o = 0, rvalid_o = 0, err_o = 0, rdata_o = 0.
  - LFSR = LFSR_SEED, all bank locations = 0, FSM = IDLE.
- Read latency is 1: accept at edge E, rdata_o/rvalid_o valid from E until E+1.
- Back-to-back reads are accepted every cycle.
- Write accepted at edge E:
  - ready_o = 0 during cycles E..E+WR_LAT.
  - Commit happens at edge E+WR_LAT, where ready_o returns to 1.
- A read accepted in the first ready cycle after a commit returns the new data. There is no read-after-write hazard, because all requests are blocked during PEND.
- Reset asserted mid-PEND: the pending write is discarded, and all state returns to reset values immediately (asynchronous reset).
- LFSR arithmetic:
  - next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : 0).
  - The LFSR never reaches 0 from a nonzero seed.
- addr_i is AW bits wide, so every address is in range and no out-of-range check is needed.

## Structure
- Package ral_pkg holds:
  - the state enum (IDLE, PEND);
  - the RO_ADDR = 0 constant;
  - default POLY/SEED constants for DW of 8, 16 and 32.
- Sub-module ral_lfsr (parameters DW, POLY, SEED; ports clk, rst_n, step_i, value_o) is instantiated once.
- The bank is a flat reg array with no memory macro. The strobe merge is done per byte in a generate loop.

## Test plan
- Reset, then read address 0 three times back-to-back with defaults -> rdata_o = 01, B8, 5C; rvalid_o is high for 3 consecutive cycles.
- Write address 3 = 8'h5A (wstrb = 1) -> ready_o low for exactly 4 cycles; an immediate read of address 3 after ready_o returns 5A.
- Write address 0 = 8'hFF -> err_o is a one-cycle pulse, ready_o stays 1, and a following read of address 0 still returns the unchanged LFSR sequence.
- With DW = 16: write address 2 = 16'hABCD, wstrb = 2'b11, then write 16'h1234 with wstrb = 2'b01 -> read of address 2 returns 16'hAB34.
- Assert a write with WR_LAT = 4, then pulse rst_n low in the cycle after acceptance -> no commit, the location reads 0, and ready_o = 1 immediately.
- With WR_LAT = 1, hold req_i for back-to-back writes to addresses 1..7 -> each write is accepted every 2 cycles, and all 7 values read back correctly.

Source files
------------

// File: rtl/ral_pkg.sv
// Shared state encoding and LFSR defaults for the RAL register bank.
// Pure declarations: no timing and no handshake here.
package ral_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam int RO_ADDR = 0;

    localparam logic [7:0]  POLY8  = 8'hB8;
    localparam logic [15:0] POLY16 = 16'hB400;
    localparam logic [31:0] POLY32 = 32'h8020_0003;
    localparam logic [7:0]  SEED8  = 8'h01;
    localparam logic [15:0] SEED16 = 16'h0001;
    localparam logic [31:0] SEED32 = 32'h0000_0001;

    function automatic logic [31:0] default_poly(input int dw);
        case (dw)
            16:      return 32'(POLY16);
            32:      return POLY32;
            default: return 32'(POLY8);
        endcase
    endfunction

    function automatic logic [31:0] default_seed(input int dw);
        case (dw)
            16:      return 32'(SEED16);
            32:      return SEED32;
            default: return 32'(SEED8);
        endcase
    endfunction

endpackage

// File: rtl/ral_lfsr.sv
// Right-shifting Galois LFSR; advances one step on each cycle step_i is high.
// value_o is registered and always available, no backpressure.
module ral_lfsr
    import ral_pkg::*;
#(
    parameter int            DW   = 8,
    parameter logic [DW-1:0] POLY = DW'(default_poly(DW)),
    parameter logic [DW-1:0] SEED = DW'(default_seed(DW))
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step_i,
    output logic [DW-1:0] value_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_o <= SEED;
        end else if (step_i) begin
            value_o <= (value_o >> 1) ^ (value_o[0] ? POLY : '0);
        end
    end

endmodule

// File: rtl/ral_reg_bank.sv
// Register bank: address 0 reads the LFSR, others are byte-maskable storage; reads take 1 cycle.
// Writes commit WR_LAT cycles after acceptance; ready_o stays low (all requests ignored) until then.
module ral_reg_bank
    import ral_pkg::*;
#(
    parameter int            DW        = 8,
    parameter int            AW        = 3,
    parameter int            WR_LAT    = 4,
    parameter logic [DW-1:0] LFSR_POLY = DW'(default_poly(DW)),
    parameter logic [DW-1:0] LFSR_SEED = DW'(default_seed(DW))
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic [DW/8-1:0] wstrb_i,
    output logic            ready_o,
    output logic            rvalid_o,
    output logic [DW-1:0]   rdata_o,
    output logic            err_o,
    output logic            busy_o
);

    localparam int NB = DW / 8;
    localparam int N  = 2 ** AW;
    localparam int CW = 4;
    localparam logic [AW-1:0] RO = AW'(RO_ADDR);

    state_t          state;
    logic            ready;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pdata;
    logic [NB-1:0]   pstrb;
    logic [DW-1:0]   bank [N];
    logic [DW-1:0]   merged;
    logic [DW-1:0]   lfsr_value;
    logic            accept;
    logic            rd_acc;
    logic            wr_acc;
    logic            ro_wr;
    logic            lfsr_step;
    logic            commit;

    assign accept    = req_i && ready;
    assign rd_acc    = accept && !we_i;
    assign ro_wr     = accept && we_i && (addr_i == RO);
    assign wr_acc    = accept && we_i && (addr_i != RO);
    assign lfsr_step = rd_acc && (addr_i == RO);
    assign commit    = (state == PEND) && (cnt == '0);

    assign ready_o = ready;
    assign busy_o  = ~ready;

    ral_lfsr #(
        .DW   (DW),
        .POLY (LFSR_POLY),
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_i  (lfsr_step),
        .value_o (lfsr_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ready <= 1'b1;
            cnt   <= '0;
            paddr <= '0;
            pdata <= '0;
            pstrb <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_acc) begin
                        state <= PEND;
                        ready <= 1'b0;
                        cnt   <= CW'(WR_LAT - 1);
                        paddr <= addr_i;
                        pdata <= wdata_i;
                        pstrb <= wstrb_i;
                    end
                end
                PEND: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // Unstrobed bytes keep the location's current contents.
    for (genvar b = 0; b < NB; b++) begin : g_merge
        assign merged[8*b +: 8] = pstrb[b] ? pdata[8*b +: 8] : bank[paddr][8*b +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                bank[i] <= '0;
            end
        end else if (commit) begin
            bank[paddr] <= merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= rd_acc;
            err_o    <= ro_wr;
            if (rd_acc) begin
                rdata_o <= (addr_i == RO) ? lfsr_value : bank[addr_i];
            end
        end
    end

endmodule
